rx_capture_buffer: RTL
======================

Name: rx_capture_buffer

Overview:
- Parametrised pre/post-trigger sample capture buffer for the RX chain; successor to the fixed 32x1024 simple dual-port BRAM.
- Continuously records incoming samples into a circular RAM. On a trigger it freezes a window of PRE_TRIG samples before the trigger and DEPTH-PRE_TRIG samples from the trigger onward.
- Downstream logic (correlator, host readout) reads the window by relative index 0..DEPTH-1, oldest first.

Parameters:
- DATA_W, 32, sample width in bits (signed).
- ADDR_W, 10, RAM address width; DEPTH = 2**ADDR_W.
- PRE_TRIG, 256, number of samples kept before the trigger sample. Legal range 1..DEPTH-1; checked at elaboration.

Ports:
- crx_clk  in  1  clock
- rrx_rst  in  1  synchronous active-high reset
- erx_en  in  1  global enable; low freezes all state
- istart  in  1  one-cycle pulse: begin a new capture
- isample_valid  in  1  isample is valid this cycle
- isample  in  DATA_W  signed input sample
- itrigger  in  1  trigger; qualified only when isample_valid=1
- ird_req  in  1  read request
- ird_idx  in  ADDR_W  relative read index (0 = oldest sample in window)
- odata_out  out  DATA_W  read data
- odata_valid  out  1  odata_out valid
- obusy  out  1  capture in progress (FILL, ARMED or POST)
- odone  out  1  window frozen and readable

Behaviour:
- Clocking and reset: one clock, crx_clk. rrx_rst is synchronous and active-high.
- Reset: state=IDLE; wr_ptr=0; counters=0; odata_out=0; odata_valid=0; obusy=0; odone=0. RAM contents are not cleared (initialised to 0 at configuration only).
- State machine: IDLE, FILL, ARMED, POST, DONE.
  - IDLE: istart -> FILL with fill_cnt=0. Samples are not written.
  - FILL: each valid sample is written at wr_ptr, then wr_ptr++ (mod DEPTH) and fill_cnt++. When fill_cnt reaches PRE_TRIG -> ARMED. itrigger is ignored in FILL.
  - ARMED: valid samples are written circularly. A valid sample with itrigger=1 is the trigger sample: it is written, trig_addr=wr_ptr is latched, post_cnt=1, and the state moves to POST. If DEPTH-PRE_TRIG=1, it goes directly to DONE.
  - POST: valid samples are written and post_cnt++. The sample that makes post_cnt = DEPTH-PRE_TRIG moves the state to DONE in the same cycle, after its write. itrigger is ignored.
  - DONE: no writes. Reads are enabled.
- istart in any state other than IDLE/DONE restarts FILL. It resets fill_cnt and leaves wr_ptr unchanged.
- istart in DONE also restarts FILL; odone drops the next cycle.
- istart and a valid sample in the same cycle: the sample is the first FILL sample.
- Window base: base = trig_addr - PRE_TRIG (mod DEPTH). Read address = base + ird_idx (mod DEPTH), wrapping naturally in ADDR_W bits.
- Read latency is 1 cycle. ird_req in DONE with erx_en=1 gives odata_out = window[ird_idx] and odata_valid=1 on the next edge.
- ird_req outside DONE is ignored: odata_valid=0, odata_out holds.
- odata_valid is otherwise 0, with no stall or backpressure. Back-to-back reads are allowed every cycle.
- erx_en=0: no writes, no state or counter change, odata_valid=0 and odata_out=0 on the next edge.
- obusy=1 in FILL/ARMED/POST. odone=1 in DONE. Both are registered.
- Write/read collision: impossible, since reads occur only in DONE.

Decomposition:
- Shared package rx_pkg holds the state encoding, with localparams ST_IDLE..ST_DONE (3-bit).
- One sub-module: rx_bram_sdp, a parametrised simple dual-port RAM (DATA_W, ADDR_W).
  - Single clock; write enable/address/data; read enable/address; registered output.
  - Synchronous reset of the output register only.
  - Zero-initialised.
- The top level holds the FSM, pointers, counters and the address adder.

Test Plan:
- Reset mid-POST: rrx_rst for 1 cycle -> next cycle obusy=0, odone=0, odata_valid=0, state IDLE. Samples are not written until istart.
- Trigger ignored in FILL: istart, samples 0,1,2,... with itrigger high on sample 100, and again on sample 300 -> trigger taken at sample 300, odone after sample 1067. Read idx0=44, idx256=300, idx1023=1067.
- Wrap-around: pre-fill with 5000 samples before the trigger, trigger at value 5000 -> base address wraps. Read idx255=4999, idx256=5000, idx1023=5767.
- Read latency and gating: in DONE, ird_req on idx 0..3 back-to-back -> odata_valid high for 4 consecutive cycles, 1 cycle delayed. ird_req during POST -> odata_valid=0.
- erx_en low: drop erx_en for 10 cycles during POST while driving samples -> those samples are not written, post_cnt frozen, odata_valid=0. Capture resumes correctly afterwards.
- Parameter sweep: ADDR_W=4, DATA_W=16, PRE_TRIG=1. Trigger on sample 20 -> idx0=19, idx1=20, idx15=34. With PRE_TRIG=15, idx15=20 and odone is asserted the cycle of the trigger sample.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared definitions for the RX capture buffer: capture state encoding and helpers.
package rx_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } rx_state_e;

  // A capture is in progress while samples are still being recorded.
  function automatic logic is_capturing(rx_state_e s);
    return (s == ST_FILL) || (s == ST_ARMED) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/rx_capture_buffer_if.sv
// Sample, trigger, control and readout bundle of the RX capture buffer.
interface rx_capture_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic                     erx_en;
  logic                     istart;
  logic                     isample_valid;
  logic signed [DATA_W-1:0] isample;
  logic                     itrigger;
  logic                     ird_req;
  logic [ADDR_W-1:0]        ird_idx;
  logic signed [DATA_W-1:0] odata_out;
  logic                     odata_valid;
  logic                     obusy;
  logic                     odone;

  modport master (
    output erx_en, istart, isample_valid, isample, itrigger, ird_req, ird_idx,
    input  odata_out, odata_valid, obusy, odone
  );

  modport slave (
    input  erx_en, istart, isample_valid, isample, itrigger, ird_req, ird_idx,
    output odata_out, odata_valid, obusy, odone
  );
endinterface

// File: rtl/rx_bram_sdp.sv
// Simple dual-port RAM, single clock, registered read port with synchronous output clear.
module rx_bram_sdp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Contents are not reset; power-up contents come from the configuration image (zero).
  logic signed [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read stage boundary: one-cycle registered output.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rx_capture_buffer.sv
// Pre/post-trigger capture buffer: records samples circularly and freezes a DEPTH-sample
// window around a qualified trigger, readable by relative index (0 = oldest).
module rx_capture_buffer
  import rx_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int PRE_TRIG = 256
) (
  input  logic          crx_clk,
  input  logic          rrx_rst,
  rx_capture_buffer_if.slave bus
);

  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int POST_LEN = DEPTH - PRE_TRIG;
  localparam int CNT_W    = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  PRE_C  = CNT_W'(PRE_TRIG);
  localparam logic [CNT_W-1:0]  POST_C = CNT_W'(POST_LEN);
  localparam logic [ADDR_W-1:0] PRE_A  = ADDR_W'(PRE_TRIG);

  if (PRE_TRIG < 1 || PRE_TRIG > DEPTH - 1) begin : g_bad_pre_trig
    $error("rx_capture_buffer: PRE_TRIG must lie in 1..DEPTH-1");
  end

  rx_state_e         state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  fill_cnt;
  logic [CNT_W-1:0]  post_cnt;
  logic              wr_en;
  logic              rd_en;
  logic              vld_p1;
  logic              busy_q;
  logic              done_q;

  // A start pulse makes a coincident valid sample the first FILL sample.
  assign wr_en   = bus.erx_en && bus.isample_valid && (bus.istart || is_capturing(state));
  assign rd_en   = bus.erx_en && bus.ird_req && (state == ST_DONE);
  // Window base is PRE_TRIG behind the trigger; both adds wrap in ADDR_W bits.
  assign rd_addr = trig_addr - PRE_A + bus.ird_idx;

  assign bus.odata_valid = vld_p1;
  assign bus.obusy       = busy_q;
  assign bus.odone       = done_q;

  always_ff @(posedge crx_clk) begin
    if (rrx_rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      trig_addr <= '0;
      fill_cnt  <= '0;
      post_cnt  <= '0;
      vld_p1    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (!bus.erx_en) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (bus.istart) begin
        fill_cnt <= bus.isample_valid ? CNT_W'(1) : '0;
        state    <= (bus.isample_valid && PRE_TRIG == 1) ? ST_ARMED : ST_FILL;
        busy_q   <= 1'b1;
        done_q   <= 1'b0;
      end else begin
        case (state)
          ST_FILL: begin
            if (bus.isample_valid) begin
              fill_cnt <= fill_cnt + 1'b1;
              if (fill_cnt + 1'b1 == PRE_C) state <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (bus.isample_valid && bus.itrigger) begin
              trig_addr <= wr_ptr;
              post_cnt  <= CNT_W'(1);
              if (POST_LEN == 1) begin
                state  <= ST_DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end else begin
                state <= ST_POST;
              end
            end
          end
          ST_POST: begin
            if (bus.isample_valid) begin
              post_cnt <= post_cnt + 1'b1;
              if (post_cnt + 1'b1 == POST_C) begin
                state  <= ST_DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  rx_bram_sdp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (crx_clk),
    .rst     (rrx_rst || !bus.erx_en),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (bus.isample),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (bus.odata_out)
  );

endmodule
